// File: rtl/lcd_line_writer_if.sv
// Bundle of signals between the text console, the line writer and the LCD pins.
// The writer uses the master view; the console/LCD side uses the slave view.
interface lcd_line_writer_if;
    logic [127:0] line_data;
    logic         refresh;
    logic [7:0]   lcd_data;
    logic         lcd_rs;
    logic         lcd_rw;
    logic         lcd_en;
    logic         busy;
    logic         done;

    modport master (
        input  line_data,
        input  refresh,
        output lcd_data,
        output lcd_rs,
        output lcd_rw,
        output lcd_en,
        output busy,
        output done
    );

    modport slave (
        output line_data,
        output refresh,
        input  lcd_data,
        input  lcd_rs,
        input  lcd_rw,
        input  lcd_en,
        input  busy,
        input  done
    );
endinterface

// File: rtl/lcd_line_writer.sv
// HD44780 line writer: runs the power-up init, then rewrites line 1 with a
// 16-character text whenever the text changes or a refresh is requested.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// PWR_WAIT | waiting out the LCD power-up delay after reset
// INIT     | sending 0x38, 0x0C, 0x06, 0x01 (function set .. clear)
// IDLE     | waiting for pending, refresh or a text change
// ADDR     | sending 0x80 (DDRAM address 0, line 1)
// CHAR     | sending the 16 shadowed characters, idx 0..15
//
// Every byte in INIT/ADDR/CHAR goes through SETUP (1 cycle, en low),
// STROBE (EN_HIGH_CYCLES, en high) and HOLD (wait cycles, en low).
// rs/data are loaded on the edge that enters SETUP and are left alone until
// the next byte's SETUP, so they are stable for the whole transfer.
module lcd_line_writer #(
    parameter int unsigned POWERUP_CYCLES    = 750000,
    parameter int unsigned EN_HIGH_CYCLES    = 25,
    parameter int unsigned CMD_WAIT_CYCLES   = 2500,
    parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    lcd_line_writer_if.master  bus
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        ADDR,
        CHAR
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } phase_t;

    // Terminal counts for the single up-counting timer (all values < 2^20).
    localparam logic [19:0] PWR_TC = 20'(POWERUP_CYCLES - 1);
    localparam logic [19:0] EN_TC  = 20'(EN_HIGH_CYCLES - 1);
    localparam logic [19:0] CMD_TC = 20'(CMD_WAIT_CYCLES - 1);
    localparam logic [19:0] CLR_TC = 20'(CLEAR_WAIT_CYCLES - 1);

    state_t        state;
    phase_t        phase;
    logic [19:0]   timer;
    logic [3:0]    idx;
    logic [127:0]  shadow;
    logic          pending;
    logic [7:0]    lcd_data_q;
    logic          lcd_rs_q;
    logic          lcd_en_q;
    logic          busy_q;
    logic          done_q;
    logic [19:0]   hold_tc;

    // Init command table, indexed by the low bits of idx while in INIT.
    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        logic [7:0] c;
        case (i)
            2'd0:    c = 8'h38;
            2'd1:    c = 8'h0C;
            2'd2:    c = 8'h06;
            default: c = 8'h01;
        endcase
        return c;
    endfunction

    // Character k of a line (k = 0 is leftmost); NUL is shown as a space.
    function automatic logic [7:0] char_at(input logic [127:0] s, input logic [3:0] k);
        logic [127:0] t;
        t = s << {k, 3'b000};
        return (t[127:120] == 8'h00) ? 8'h20 : t[127:120];
    endfunction

    // Only the clear command needs the long post-strobe wait; a data byte
    // of 0x01 (rs=1) is an ordinary character.
    assign hold_tc = (!lcd_rs_q && lcd_data_q == 8'h01) ? CLR_TC : CMD_TC;

    // Sequencer: state, byte phase, timer, text shadow and registered pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= PWR_WAIT;
            phase      <= PH_SETUP;
            timer      <= '0;
            idx        <= '0;
            shadow     <= {16{8'h20}};
            pending    <= 1'b0;
            lcd_data_q <= 8'h00;
            lcd_rs_q   <= 1'b0;
            lcd_en_q   <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Refresh requests seen while busy are merged into one later update.
            if (bus.refresh && state != IDLE) begin
                pending <= 1'b1;
            end

            case (state)
                PWR_WAIT: begin
                    if (timer == PWR_TC) begin
                        timer      <= '0;
                        state      <= INIT;
                        phase      <= PH_SETUP;
                        idx        <= '0;
                        lcd_data_q <= init_cmd(2'd0);
                        lcd_rs_q   <= 1'b0;
                    end else begin
                        timer <= timer + 20'd1;
                    end
                end

                IDLE: begin
                    if (pending || bus.refresh || bus.line_data != shadow) begin
                        shadow     <= bus.line_data;
                        pending    <= 1'b0;
                        state      <= ADDR;
                        phase      <= PH_SETUP;
                        timer      <= '0;
                        idx        <= '0;
                        lcd_data_q <= 8'h80;
                        lcd_rs_q   <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end

                default: begin
                    case (phase)
                        PH_SETUP: begin
                            phase    <= PH_STROBE;
                            lcd_en_q <= 1'b1;
                            timer    <= '0;
                        end

                        PH_STROBE: begin
                            if (timer == EN_TC) begin
                                phase    <= PH_HOLD;
                                lcd_en_q <= 1'b0;
                                timer    <= '0;
                            end else begin
                                timer <= timer + 20'd1;
                            end
                        end

                        PH_HOLD: begin
                            if (timer == hold_tc) begin
                                timer <= '0;
                                phase <= PH_SETUP;
                                case (state)
                                    INIT: begin
                                        if (idx == 4'd3) begin
                                            state   <= IDLE;
                                            pending <= 1'b1;
                                            idx     <= '0;
                                            busy_q  <= 1'b0;
                                        end else begin
                                            idx        <= idx + 4'd1;
                                            lcd_data_q <= init_cmd(idx[1:0] + 2'd1);
                                            lcd_rs_q   <= 1'b0;
                                        end
                                    end

                                    ADDR: begin
                                        state      <= CHAR;
                                        idx        <= '0;
                                        lcd_data_q <= char_at(shadow, 4'd0);
                                        lcd_rs_q   <= 1'b1;
                                    end

                                    CHAR: begin
                                        if (idx == 4'd15) begin
                                            state  <= IDLE;
                                            idx    <= '0;
                                            done_q <= 1'b1;
                                            busy_q <= 1'b0;
                                        end else begin
                                            idx        <= idx + 4'd1;
                                            lcd_data_q <= char_at(shadow, idx + 4'd1);
                                            lcd_rs_q   <= 1'b1;
                                        end
                                    end

                                    default: state <= IDLE;
                                endcase
                            end else begin
                                timer <= timer + 20'd1;
                            end
                        end

                        default: phase <= PH_SETUP;
                    endcase
                end
            endcase
        end
    end

    assign bus.lcd_data = lcd_data_q;
    assign bus.lcd_rs   = lcd_rs_q;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_en   = lcd_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_lcd_line_writer.sv
// Directed bench for lcd_line_writer with POWERUP=10, EN_HIGH=2,
// CMD_WAIT=4, CLEAR_WAIT=8 (Tcmd=7, Tclr=11). Cycle 0 is the cycle that
// follows the last reset edge; outputs are sampled on the falling edge.
module tb_lcd_line_writer;

    logic clk;
    logic rst_n;

    lcd_line_writer_if bus ();

    lcd_line_writer #(
        .POWERUP_CYCLES   (10),
        .EN_HIGH_CYCLES   (2),
        .CMD_WAIT_CYCLES  (4),
        .CLEAR_WAIT_CYCLES(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Strobe monitor: one entry per lcd_en pulse ({rs,data}, rise cycle, width).
    int         ncyc = 0;
    logic [8:0] bq[$];
    int         rq[$];
    int         wq[$];
    logic       en_prev = 1'b0;
    int         wcnt = 0;

    always @(posedge clk) ncyc <= ncyc + 1;

    always @(negedge clk) begin
        if (bus.lcd_en === 1'b1) begin
            if (en_prev !== 1'b1) begin
                bq.push_back({bus.lcd_rs, bus.lcd_data});
                rq.push_back(ncyc);
                wcnt = 0;
            end
            wcnt = wcnt + 1;
        end else if (en_prev === 1'b1) begin
            wq.push_back(wcnt);
        end
        en_prev = bus.lcd_en;
    end

    int base = 0;
    int bi   = 0;
    int wi   = 0;

    logic [7:0] init_cmds [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    // "SW0  SW1" zero-extended: 0x80, eight blanks, then the text.
    logic [8:0] exp_first [17] = '{9'h080,
                                   9'h120, 9'h120, 9'h120, 9'h120,
                                   9'h120, 9'h120, 9'h120, 9'h120,
                                   9'h153, 9'h157, 9'h130, 9'h120,
                                   9'h120, 9'h153, 9'h157, 9'h131};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Byte i of a line update: 0 is the address command, 1..16 the characters.
    function automatic logic [8:0] exp_byte(input logic [127:0] t, input int i);
        logic [7:0] ch;
        if (i == 0) return 9'h080;
        ch = t[127 - 8*(i-1) -: 8];
        return (ch == 8'h00) ? 9'h120 : {1'b1, ch};
    endfunction

    task automatic wait_done(input int limit, output int at);
        at = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                at = ncyc - base;
                break;
            end
        end
    endtask

    task automatic wait_busy_low(input int limit, output int at);
        at = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin
                at = ncyc - base;
                break;
            end
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        base  = ncyc;
        bi    = bq.size();
        wi    = wq.size();
    endtask

    task automatic check_init(input string tag);
        int at;
        wait_busy_low(200, at);
        chk({tag, "_idle_cycle"}, at, 42);
        chk({tag, "_idle_done"}, bus.done, 0);
        chk({tag, "_byte_count"}, bq.size() - bi, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), bq[bi+i], {1'b0, init_cmds[i]});
            chk($sformatf("%s_rise%0d", tag, i), rq[bi+i] - base, 11 + 7*i);
            chk($sformatf("%s_width%0d", tag, i), wq[bi+i], 2);
        end
    endtask

    task automatic check_line(input int s, input logic [127:0] t, input string tag);
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), bq[s+i], exp_byte(t, i));
            chk($sformatf("%s_width%0d", tag, i), wq[s+i], 2);
        end
    endtask

    logic [63:0]  sw_txt;
    logic [127:0] text_a;
    logic [127:0] text_b;
    logic [127:0] text_c;
    int at;
    int s;
    int cnt_en;
    int cnt_busy;
    int cnt_done;
    int rises;
    logic prev_en;
    logic found;

    initial begin
        sw_txt = "SW0  SW1";
        text_a = "ABCDEFGHIJKLMNOP";
        text_b = "HELLO WORLD 1234";
        text_c = "0123456789abcdef";

        rst_n          = 1'b0;
        bus.refresh    = 1'b0;
        bus.line_data  = {64'h0, sw_txt};
        repeat (3) @(negedge clk);

        chk("rst_en",   bus.lcd_en,   0);
        chk("rst_rs",   bus.lcd_rs,   0);
        chk("rst_rw",   bus.lcd_rw,   0);
        chk("rst_data", bus.lcd_data, 0);
        chk("rst_busy", bus.busy,     1);
        chk("rst_done", bus.done,     0);

        // Power-up wait and init sequence, then the forced first write.
        release_reset();
        check_init("init");
        wait_done(300, at);
        chk("first_done_cycle", at, 162);
        chk("first_done_busy", bus.busy, 0);
        chk("first_byte_count", bq.size() - bi, 21);
        for (int i = 0; i < 17; i++)
            chk($sformatf("first_byte%0d", i), bq[bi+4+i], exp_first[i]);
        chk("first_addr_rise", rq[bi+4] - base, 44);
        chk("first_last_rise", rq[bi+20] - base, 156);
        @(negedge clk);
        chk("first_done_width", bus.done, 0);
        chk("first_stays_idle", bus.busy, 0);

        // Text change during char 5: old text finishes, then new text follows.
        s = bq.size();
        bus.line_data = text_a;
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bq.size() >= s + 7) begin
                found = 1'b1;
                break;
            end
        end
        chk("mid_reached_char5", found, 1);
        bus.line_data = text_b;
        wait_done(300, at);
        chk("mid_a_done", at >= 0, 1);
        chk("mid_gap_busy_low", bus.busy, 0);
        check_line(s, text_a, "mid_a");
        @(negedge clk);
        chk("mid_gap_busy_high", bus.busy, 1);
        wait_done(300, at);
        chk("mid_b_done", at >= 0, 1);
        check_line(s + 17, text_b, "mid_b");

        // Stable inputs: nothing moves on the bus.
        cnt_en = 0;
        cnt_busy = 0;
        cnt_done = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (bus.lcd_en !== 1'b0) cnt_en++;
            if (bus.busy !== 1'b0) cnt_busy++;
            if (bus.done !== 1'b0) cnt_done++;
        end
        chk("quiet_en_cycles", cnt_en, 0);
        chk("quiet_busy_cycles", cnt_busy, 0);
        chk("quiet_done_cycles", cnt_done, 0);

        // Refresh in IDLE, plus three merged refreshes during that update.
        s = bq.size();
        bus.refresh = 1'b1;
        @(negedge clk);
        bus.refresh = 1'b0;
        for (int p = 0; p < 3; p++) begin
            repeat (20) @(negedge clk);
            bus.refresh = 1'b1;
            @(negedge clk);
            bus.refresh = 1'b0;
        end
        wait_done(300, at);
        chk("refresh_done1", at >= 0, 1);
        wait_done(300, at);
        chk("refresh_done2", at >= 0, 1);
        cnt_busy = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) cnt_busy++;
        end
        chk("refresh_after_busy", cnt_busy, 0);
        chk("refresh_byte_count", bq.size() - s, 34);
        check_line(s + 17, text_b, "refresh_2nd");

        // Refresh and a text change in the same IDLE cycle: one update.
        s = bq.size();
        bus.refresh   = 1'b1;
        bus.line_data = text_c;
        @(negedge clk);
        bus.refresh = 1'b0;
        wait_done(300, at);
        chk("both_done", at >= 0, 1);
        repeat (200) @(negedge clk);
        chk("both_byte_count", bq.size() - s, 17);
        check_line(s, text_c, "both");

        // Reset while lcd_en is high on char 1.
        s = bq.size();
        bus.refresh = 1'b1;
        @(negedge clk);
        bus.refresh = 1'b0;
        rises   = 0;
        prev_en = 1'b0;
        found   = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.lcd_en === 1'b1 && prev_en !== 1'b1) begin
                rises++;
                if (rises == 3) begin
                    found = 1'b1;
                    break;
                end
            end
            prev_en = bus.lcd_en;
        end
        chk("rstmid_strobe_found", found, 1);
        chk("rstmid_strobe_rs", bus.lcd_rs, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_en",   bus.lcd_en,   0);
        chk("rstmid_data", bus.lcd_data, 0);
        chk("rstmid_rs",   bus.lcd_rs,   0);
        chk("rstmid_busy", bus.busy,     1);
        chk("rstmid_done", bus.done,     0);
        @(negedge clk);
        release_reset();
        check_init("reinit");
        wait_done(300, at);
        chk("reinit_done_cycle", at, 162);
        check_line(bi + 4, text_c, "reinit_line");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
